// File: rtl/alu_reg_file.sv
// Operand register file for the ALU: three combinational read ports (x, y, m),
// an ALU write-back port, a handshaked load port and a registered branch flag.
module alu_reg_file #(
  parameter int NREG  = 16,
  parameter int AW    = 4,
  parameter int M_IDX = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] x_addr,
  input  logic [AW-1:0] y_addr,
  output logic [7:0]    x,
  output logic [7:0]    y,
  output logic [7:0]    m,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic          alu_rs,
  input  logic [7:0]    r_out,
  input  logic [7:0]    s_out,
  input  logic          flag_we,
  output logic          flag,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          ld_ready
);

  localparam logic [AW-1:0] M_ADDR = AW'(M_IDX);

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_WAIT = 1'b1
  } ld_state_e;

  logic [7:0] regs_q [NREG];
  logic [7:0] regs_d [NREG];
  logic       flag_q, flag_d;
  ld_state_e  ld_state_q, ld_state_d;
  logic [7:0] blocked_cycles_q, blocked_cycles_d;

  logic       wb_fire;
  logic       ld_fire;
  logic [7:0] wb_data;

  // Handshake: a load transfers on an edge where ld_valid && ld_ready. The
  // source must hold ld_valid/ld_addr/ld_data stable until that edge; ready
  // drops only for reset or a same-address ALU write-back, which wins.
  assign ld_ready = !reset && !(wb_en && (wb_addr == ld_addr));
  assign ld_fire  = ld_valid && ld_ready;
  assign wb_fire  = wb_en && !reset;
  assign wb_data  = alu_rs ? s_out : r_out;

  // Next register contents double as the write-through bypass for the reads;
  // the write-back is applied last so it takes priority in the bypass.
  always_comb begin
    regs_d = regs_q;
    if (ld_fire) regs_d[ld_addr] = ld_data;
    if (wb_fire) regs_d[wb_addr] = wb_data;
  end

  assign x = regs_d[x_addr];
  assign y = regs_d[y_addr];
  assign m = regs_d[M_ADDR];

  always_comb begin
    flag_d = flag_q;
    if (wb_fire && alu_rs && flag_we) flag_d = s_out[0];
  end

  assign flag = flag_q;

  always_comb begin
    ld_state_d       = LD_IDLE;
    blocked_cycles_d = 8'd0;
    if (!reset && ld_valid && !ld_ready) begin
      ld_state_d       = LD_WAIT;
      blocked_cycles_d = (blocked_cycles_q == 8'hFF) ? 8'hFF : blocked_cycles_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q           <= '{default: 8'd0};
      flag_q           <= 1'b0;
      ld_state_q       <= LD_IDLE;
      blocked_cycles_q <= 8'd0;
    end else begin
      regs_q           <= regs_d;
      flag_q           <= flag_d;
      ld_state_q       <= ld_state_d;
      blocked_cycles_q <= blocked_cycles_d;
    end
  end

endmodule

// File: doc/alu_reg_file.md
Name: alu_reg_file

Overview:
- Operand register file for the ALU: supplies operands x, y and m, and accepts write-back of the ALU result.
- Write-back selects between the ALU's r_out (logic/shift/rotate) and s_out (add/sub/compare/reverse/parity) under the same alu_rs select the ALU uses.
- A second write port accepts load data from data memory through a valid/ready handshake.
- Keeps a 1-bit condition flag taken from s_out[0] (EQL8/EQL5/PARx/PARy results) for the branch unit.

Parameters:
- NREG, 16, number of 8-bit registers; must be a power of 2.
- AW, 4, address width, equal to log2(NREG).
- M_IDX, 15, index of the register permanently driven onto m.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- x_addr  input  AW  read address for operand x.
- y_addr  input  AW  read address for operand y.
- x  output  8  operand x to the ALU.
- y  output  8  operand y to the ALU.
- m  output  8  contents of register M_IDX, to the ALU m input.
- wb_en  input  1  ALU write-back request this cycle.
- wb_addr  input  AW  ALU write-back destination.
- alu_rs  input  1  write-back select: 0 writes r_out, 1 writes s_out.
- r_out  input  8  ALU logic result.
- s_out  input  8  ALU arithmetic/compare result.
- flag_we  input  1  update flag from s_out[0]; honoured only when wb_en=1 and alu_rs=1.
- flag  output  1  registered condition flag.
- ld_valid  input  1  load data available.
- ld_addr  input  AW  load destination register.
- ld_data  input  8  load data.
- ld_ready  output  1  load port accepts this cycle.

Behaviour:
- Reset (synchronous, active-high):
  - All registers and flag go to 0 at the edge where reset=1; x, y and m then read 0.
  - ld_ready=0 while reset=1.
  - All writes presented in a reset cycle are discarded, including any held in mid-handshake; the load source must re-present after reset.
- Reads:
  - Combinational from the current register contents.
  - Write-through bypass: if the selected address matches an accepted write in the same cycle, x/y/m show the write data. When both write ports target the same address, the ALU write-back data is bypassed.
  - Reads never stall.
- ALU write-back:
  - When wb_en=1, on the next edge reg[wb_addr] <= (alu_rs ? s_out : r_out).
  - Write-back latency is 1 cycle; the new value is visible combinationally in the same cycle through the bypass.
- Flag:
  - On an edge with wb_en=1, alu_rs=1 and flag_we=1, flag <= s_out[0]; otherwise flag holds.
  - flag_we with alu_rs=0 or wb_en=0 is ignored.
- Load port:
  - ld_ready = !reset && !(wb_en && wb_addr==ld_addr).
  - A transfer occurs on an edge where ld_valid && ld_ready; reg[ld_addr] <= ld_data.
  - Loads to a different address than the write-back in the same cycle both commit that cycle.
  - On an address conflict the ALU write wins and the load stalls: the source holds ld_valid, ld_addr and ld_data until ld_ready=1. The load then commits, so the final value is the load data.
  - ld_ready may be asserted while ld_valid=0 and has no effect.
- M_IDX register is an ordinary register for both writes; m always reflects it, including the bypass.
- Addresses wrap naturally within AW bits; there are no out-of-range cases.
- State machine for the load port (two states):
  - IDLE: ld_valid=0, or the transfer completes this cycle.
  - WAIT: ld_valid=1 and blocked by a conflict. WAIT→IDLE on the first non-conflict cycle; reset→IDLE.
  - A blocked_cycles counter (8-bit, saturating, internal, visible to the bench hierarchically) counts consecutive WAIT cycles and clears on leaving WAIT.

Test Plan:
- Reset, then read all addresses → x=y=m=0, flag=0; ld_valid=1 during reset → ld_ready=0, no register written.
- wb_en=1, wb_addr=3, alu_rs=0, r_out=8'b00111100, s_out=8'hAA, x_addr=3 → x=8'b00111100 in the same cycle (bypass); reg3=8'h3C after the edge.
- wb_en=1, wb_addr=5, alu_rs=1, s_out=8'h01, flag_we=1 → flag=1 after the edge; repeat with alu_rs=0, r_out=8'h00, flag_we=1 → flag stays 1.
- Same cycle: wb_addr=2 with s_out=8'h12 and ld_addr=2 with ld_data=8'h77 → ld_ready=0 and reg2=8'h12; next cycle wb_en=0 → ld_ready=1 and reg2=8'h77.
- Same cycle: wb_addr=1 with r_out=8'hF0 and ld_addr=15 with ld_data=8'hAC → both commit; m=8'hAC the same cycle via bypass and after the edge.
- Hold the ld_addr=4 conflict for 3 cycles, then assert reset mid-WAIT → load discarded, reg4=0, FSM in IDLE, blocked_cycles=0.
